mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Memory controller between the IF/MEM pipeline stages and the byte-wide unified RAM port. Serialises instruction fetches (4 bytes) and data loads/stores (1/2/4 bytes) into single-byte RAM cycles, and gives MEM priority over IF. It produces the `if_stall_o` / `mem_stall_o` levels that the stall controller consumes. It also gates console writes on `io_buffer_full_i`.

## Interface
Parameters:
- `IO_SEL`, default `2'b11`: value of address bits [17:16] that marks the I/O region.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global ready; low freezes the block.
- `if_req_i` in 1: IF fetch request (level).
- `if_addr_i` in 32: fetch byte address.
- `if_data_o` out 32: fetched word, little-endian.
- `if_done_o` out 1: one-cycle completion pulse.
- `mem_req_i` in 1: MEM access request (level).
- `mem_we_i` in 1: 1 = store, 0 = load.
- `mem_size_i` in 2: 00 byte, 01 half, 10 word (11 treated as word).
- `mem_addr_i` in 32: data byte address.
- `mem_wdata_i` in 32: store data; the low N bytes are used.
- `mem_rdata_o` out 32: load data, zero-extended, little-endian.
- `mem_done_o` out 1: one-cycle completion pulse.
- `ram_din_i` in 8: RAM read data, valid one cycle after its address.
- `ram_dout_o` out 8: RAM write data.
- `ram_a_o` out 32: RAM byte address.
- `ram_wr_o` out 1: RAM write strobe.
- `io_buffer_full_i` in 1: console buffer full.
- `if_stall_o` out 1: `if_req_i & ~if_done_o`, combinational.
- `mem_stall_o` out 1: `mem_req_i & ~mem_done_o`, combinational.

## Operation
- States: IDLE, RD, WR, DONE. A byte counter `cnt` (3 bits) tracks progress. The latched request holds owner (IF/MEM), base address, N (1/2/4), and write data.
- **IDLE:** arbitration happens only here.
  - `mem_req_i` beats `if_req_i`.
  - An IF request is N=4, read.
  - Request fields are latched in the accept cycle A. Requestors hold their fields until done, but the block does not depend on that after A.
- **Read, accept cycle A:** drive `ram_a_o` = base, `ram_wr_o`=0, go to RD with `cnt`=1.
- **RD with `cnt`=c:**
  - Capture `ram_din_i` into byte c-1.
  - If c<N: drive `ram_a_o` = base+c and increment `cnt`.
  - If c==N: go to DONE.
- **Write, accept cycle A:** drive byte 0 (`ram_a_o`=base, `ram_dout_o`=wdata[7:0], `ram_wr_o`=1).
  - Cycles A+k, k=1..N-1: write byte k at base+k.
  - After the last byte, go to DONE.
- **I/O write gating:** a write whose base[17:16]==`IO_SEL` and finds `io_buffer_full_i`=1 waits in IDLE without accepting; IF is not granted meanwhile.
- **DONE:**
  - Pulse the owner's `*_done_o` for exactly one cycle. Read data is presented on `if_data_o`/`mem_rdata_o` in the same cycle and held until the next completion for that owner.
  - No acceptance in DONE. Return to IDLE.
- **Address arithmetic:** base+c is 32-bit with wrap-around (0xFFFFFFFF+1 = 0). No alignment is required.
- **`rdy`=0:** state, `cnt`, latched fields and data registers hold. `ram_wr_o` is forced 0. `ram_a_o` holds the last ready-cycle value, so the in-flight read byte is still valid on resume. A done pulse due in a frozen cycle is postponed, not lost.
- **Reset:** state IDLE, `cnt`=0. All registered outputs become 0: `if_data_o`, `mem_rdata_o`, both done pulses, `ram_a_o`, `ram_dout_o`, `ram_wr_o`. Reset mid-transaction aborts it: no further RAM writes, no done pulse.

## Timing
- Read of N bytes: done at A+N+1 (byte: A+2, word: A+5).
- Write of N bytes: `ram_wr_o` high in A..A+N-1, done at A+N (byte: A+1, word: A+4).
- Next acceptance is possible at done+1 at the earliest. A request that is still high in the done cycle is not re-accepted that cycle.
- A request arriving while busy waits. Its stall output stays high until its own done.
- IF+MEM both raised at A: MEM word load completes at A+5, IF is accepted at A+6 and done at A+11.

## Test plan
- Word fetch at 0x00000100, RAM bytes 0x13,0x05,0x10,0x00 -> `ram_a_o` 0x100..0x103 over A..A+3; `if_done_o` pulses at A+5 with `if_data_o`=0x00100513; `if_stall_o` is 1 from A until A+5, then 0.
- Simultaneous IF fetch at 0x200 and MEM store word 0xDEADBEEF at 0x1000 -> writes EF,BE,AD,DE to 0x1000..0x1003 with `ram_wr_o`=1 in A..A+3; `mem_done_o` at A+4; IF accepted at A+5.
- Byte load at 0xFFFFFFFF and half load at 0xFFFFFFFF -> half reads 0xFFFFFFFF then 0x00000000; `mem_rdata_o` is zero-extended (e.g. 0x0000ABCD).
- Store byte 0x41 to 0x00030000 while `io_buffer_full_i`=1 for 5 cycles -> no `ram_wr_o` during those cycles; single write the cycle after full drops; done one cycle later.
- `rdy` low for 3 cycles during RD `cnt`=2 of a word fetch -> `ram_a_o` frozen, `ram_wr_o`=0; the completed word is correct; done is delayed by exactly 3 cycles.
- `rst` during WR after 2 of 4 bytes -> no further writes, no `mem_done_o`; all outputs 0 next cycle; a new request is accepted normally afterwards.

Source files
------------

// File: rtl/mem_arbiter.sv
// Byte-serialising memory arbiter: IF fetches and MEM loads/stores share one
// byte-wide RAM port; MEM wins arbitration, console stores wait on a full buffer.
module mem_arbiter #(
  parameter logic [1:0] IO_SEL = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_done_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_size_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_done_o,
  input  logic [7:0]  ram_din_i,
  output logic [7:0]  ram_dout_o,
  output logic [31:0] ram_a_o,
  output logic        ram_wr_o,
  input  logic        io_buffer_full_i,
  output logic        if_stall_o,
  output logic        mem_stall_o
);
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  len_q, len_d;
  logic        own_mem_q, own_mem_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic [31:0] ram_a_q, ram_a_d;
  logic [7:0]  ram_dout_q, ram_dout_d;
  logic        ram_wr;
  logic        active;
  logic        io_block;
  logic [31:0] next_addr;

  function automatic logic [2:0] size_len(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

  assign active    = rdy & ~rst;
  assign io_block  = mem_we_i & (mem_addr_i[17:16] == IO_SEL) & io_buffer_full_i;
  assign next_addr = base_q + {29'd0, cnt_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    own_mem_d   = own_mem_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr      = 1'b0;
    if (active) begin
      case (state_q)
        S_IDLE: begin
          if (mem_req_i) begin
            if (!io_block) begin
              own_mem_d = 1'b1;
              base_d    = mem_addr_i;
              len_d     = size_len(mem_size_i);
              wdata_d   = mem_wdata_i;
              buf_d     = '0;
              ram_a_d   = mem_addr_i;
              cnt_d     = 3'd1;
              if (mem_we_i) begin
                ram_dout_d = mem_wdata_i[7:0];
                ram_wr     = 1'b1;
                state_d    = (size_len(mem_size_i) == 3'd1) ? S_DONE : S_WR;
              end else begin
                state_d = S_RD;
              end
            end
          end else if (if_req_i) begin
            own_mem_d = 1'b0;
            base_d    = if_addr_i;
            len_d     = 3'd4;
            buf_d     = '0;
            ram_a_d   = if_addr_i;
            cnt_d     = 3'd1;
            state_d   = S_RD;
          end
        end
        S_RD: begin
          // RAM data arriving now belongs to the address driven last cycle
          buf_d = put_byte(buf_q, cnt_q[1:0] - 2'd1, ram_din_i);
          if (cnt_q < len_q) begin
            ram_a_d = next_addr;
            cnt_d   = cnt_q + 3'd1;
          end else begin
            state_d = S_DONE;
            if (own_mem_q) mem_rdata_d = buf_d;
            else           if_data_d   = buf_d;
          end
        end
        S_WR: begin
          ram_a_d    = next_addr;
          ram_dout_d = get_byte(wdata_q, cnt_q[1:0]);
          ram_wr     = 1'b1;
          if (cnt_q == len_q - 3'd1) state_d = S_DONE;
          else                       cnt_d   = cnt_q + 3'd1;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      len_q       <= 3'd4;
      own_mem_q   <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      own_mem_q   <= own_mem_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
    end
  end

  always_ff @(posedge clk) begin
    base_q  <= base_d;
    wdata_q <= wdata_d;
    buf_q   <= buf_d;
  end

  // Frozen cycles fall back to the held port values, so the in-flight byte stays valid
  assign ram_a_o     = ram_a_d;
  assign ram_dout_o  = ram_dout_d;
  assign ram_wr_o    = ram_wr;
  assign if_data_o   = if_data_q;
  assign mem_rdata_o = mem_rdata_q;
  assign if_done_o   = active & (state_q == S_DONE) & ~own_mem_q;
  assign mem_done_o  = active & (state_q == S_DONE) & own_mem_q;
  assign if_stall_o  = if_req_i & ~if_done_o;
  assign mem_stall_o = mem_req_i & ~mem_done_o;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte RAM model, reference byte memory and
// ready-cycle latency rules derived from the transaction lengths.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        if_req_i, mem_req_i, mem_we_i, io_buffer_full_i;
  logic [31:0] if_addr_i, mem_addr_i, mem_wdata_i;
  logic [1:0]  mem_size_i;
  logic [31:0] if_data_o, mem_rdata_o, ram_a_o;
  logic        if_done_o, mem_done_o, ram_wr_o, if_stall_o, mem_stall_o;
  logic [7:0]  ram_din_i, ram_dout_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] init_mem [logic [31:0]];
  logic [7:0] ram      [logic [31:0]];
  logic [7:0] ref_mem  [logic [31:0]];

  mem_arbiter #(.IO_SEL(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_done_o(if_done_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o),
    .mem_done_o(mem_done_o), .ram_din_i(ram_din_i), .ram_dout_o(ram_dout_o),
    .ram_a_o(ram_a_o), .ram_wr_o(ram_wr_o), .io_buffer_full_i(io_buffer_full_i),
    .if_stall_o(if_stall_o), .mem_stall_o(mem_stall_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    if (init_mem.exists(a)) return init_mem[a];
    return 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 8'h00;
  endfunction

  // Synchronous byte RAM: data for an address appears the cycle after it
  always @(posedge clk) begin
    logic [7:0] rd;
    rd = ram_rd(ram_a_o);
    if (ram_wr_o) ram[ram_a_o] = ram_dout_o;
    ram_din_i <= rd;
  end

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    init_mem[a] = b;
    ref_mem[a]  = b;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (if_data_o !== 32'h0) begin errors++; $display("FAIL rst_if_data got %h want 0", if_data_o); end
    checks++; if (mem_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_mem_rdata got %h want 0", mem_rdata_o); end
    checks++; if (ram_a_o !== 32'h0) begin errors++; $display("FAIL rst_ram_a got %h want 0", ram_a_o); end
    checks++; if (ram_dout_o !== 8'h0) begin errors++; $display("FAIL rst_ram_dout got %h want 0", ram_dout_o); end
    checks++; if ({ram_wr_o, if_done_o, mem_done_o} !== 3'b000) begin
      errors++; $display("FAIL rst_strobes got %b want 000", {ram_wr_o, if_done_o, mem_done_o}); end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_if_fetch;
    preload(32'h100, 8'h13); preload(32'h101, 8'h05);
    preload(32'h102, 8'h10); preload(32'h103, 8'h00);
    if_addr_i = 32'h100; if_req_i = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k <= 3) begin
        checks++; if (ram_a_o !== 32'h100 + 32'(k)) begin
          errors++; $display("FAIL fetch_addr k=%0d got %h want %h", k, ram_a_o, 32'h100 + 32'(k)); end
      end
      checks++; if (if_stall_o !== (k < 5)) begin
        errors++; $display("FAIL fetch_stall k=%0d got %b want %b", k, if_stall_o, (k < 5)); end
      checks++; if (if_done_o !== (k == 5)) begin
        errors++; $display("FAIL fetch_done k=%0d got %b want %b", k, if_done_o, (k == 5)); end
      if (k == 5) begin
        checks++; if (if_data_o !== 32'h00100513) begin
          errors++; $display("FAIL fetch_data got %h want 00100513", if_data_o); end
      end
      next_cycle();
    end
    if_req_i = 1'b0;
  endtask

  task automatic test_store_simul;
    logic [31:0] w, exp_if;
    w = 32'hDEADBEEF;
    exp_if = 32'h0;
    for (int k = 0; k < 4; k++) begin
      preload(32'h200 + 32'(k), 8'($urandom));
      exp_if[8*k +: 8] = ref_rd(32'h200 + 32'(k));
      ref_mem[32'h1000 + 32'(k)] = w[8*k +: 8];
    end
    if_addr_i = 32'h200; if_req_i = 1'b1;
    mem_addr_i = 32'h1000; mem_wdata_i = w; mem_we_i = 1'b1; mem_size_i = 2'b10; mem_req_i = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k <= 3) begin
        checks++; if ({ram_wr_o, ram_a_o, ram_dout_o} !== {1'b1, 32'h1000 + 32'(k), w[8*k +: 8]}) begin
          errors++; $display("FAIL store_byte k=%0d got %b/%h/%h want 1/%h/%h", k, ram_wr_o, ram_a_o,
                             ram_dout_o, 32'h1000 + 32'(k), w[8*k +: 8]); end
      end
      checks++; if (mem_done_o !== (k == 4)) begin
        errors++; $display("FAIL store_done k=%0d got %b want %b", k, mem_done_o, (k == 4)); end
      if (k == 5) begin
        checks++; if ({ram_wr_o, ram_a_o} !== {1'b0, 32'h200}) begin
          errors++; $display("FAIL if_after_store got %b/%h want 0/00000200", ram_wr_o, ram_a_o); end
      end
      checks++; if (if_done_o !== (k == 10)) begin
        errors++; $display("FAIL if_after_store_done k=%0d got %b want %b", k, if_done_o, (k == 10)); end
      if (k == 10) begin
        checks++; if (if_data_o !== exp_if) begin
          errors++; $display("FAIL if_after_store_data got %h want %h", if_data_o, exp_if); end
      end
      next_cycle();
      if (k == 4) mem_req_i = 1'b0;
    end
    if_req_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (ram_rd(32'h1000 + 32'(k)) !== w[8*k +: 8]) begin
        errors++; $display("FAIL store_ram k=%0d got %h want %h", k, ram_rd(32'h1000 + 32'(k)), w[8*k +: 8]); end
    end
  endtask

  // One request on its own; latency counted in ready cycles from acceptance
  task automatic run_xact(input bit is_mem, input bit we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata, input bit rand_rdy);
    int n, need, readies;
    bit got;
    logic d;
    logic [31:0] exp, obs;
    n = !is_mem ? 4 : (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    need = (is_mem && we) ? n + 1 : n + 2;
    exp = 32'h0;
    for (int k = 0; k < n; k++) begin
      if (is_mem && we) ref_mem[addr + 32'(k)] = wdata[8*k +: 8];
      else exp[8*k +: 8] = ref_rd(addr + 32'(k));
    end
    if (is_mem) begin
      mem_we_i = we; mem_size_i = size; mem_addr_i = addr; mem_wdata_i = wdata; mem_req_i = 1'b1;
    end else begin
      if_addr_i = addr; if_req_i = 1'b1;
    end
    readies = 0; got = 1'b0;
    for (int c = 0; c < 80 && !got; c++) begin
      rdy = (rand_rdy && c > 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (rdy) readies++;
      d   = is_mem ? mem_done_o : if_done_o;
      obs = is_mem ? mem_rdata_o : if_data_o;
      checks++;
      if (d) begin
        got = 1'b1;
        if (readies != need) begin
          errors++; $display("FAIL xact_latency addr=%h got %0d want %0d", addr, readies, need); end
        if (!(is_mem && we)) begin
          checks++; if (obs !== exp) begin
            errors++; $display("FAIL xact_data addr=%h got %h want %h", addr, obs, exp); end
        end
      end else if ((is_mem ? mem_stall_o : if_stall_o) !== 1'b1) begin
        errors++; $display("FAIL xact_stall addr=%h got 0 want 1", addr);
      end
      next_cycle();
    end
    if_req_i = 1'b0; mem_req_i = 1'b0; rdy = 1'b1;
    if (!got) begin
      checks++; errors++; $display("FAIL xact_timeout addr=%h got no done want done", addr);
    end else begin
      @(negedge clk);
      checks++; if ({if_done_o, mem_done_o} !== 2'b00) begin
        errors++; $display("FAIL xact_single_pulse got %b want 00", {if_done_o, mem_done_o}); end
      next_cycle();
      if (is_mem && we) begin
        for (int k = 0; k < n; k++) begin
          checks++; if (ram_rd(addr + 32'(k)) !== ref_rd(addr + 32'(k))) begin
            errors++; $display("FAIL xact_ram a=%h got %h want %h", addr + 32'(k),
                               ram_rd(addr + 32'(k)), ref_rd(addr + 32'(k))); end
        end
      end
    end
  endtask

  task automatic test_wrap;
    preload(32'hFFFFFFFF, 8'hCD); preload(32'h0, 8'hAB);
    run_xact(1'b1, 1'b0, 2'b00, 32'hFFFFFFFF, 32'h0, 1'b0);
    mem_we_i = 1'b0; mem_size_i = 2'b01; mem_addr_i = 32'hFFFFFFFF; mem_req_i = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++; if (ram_a_o !== 32'hFFFFFFFF) begin
          errors++; $display("FAIL wrap_addr0 got %h want ffffffff", ram_a_o); end
      end
      if (k == 1) begin
        checks++; if (ram_a_o !== 32'h0) begin
          errors++; $display("FAIL wrap_addr1 got %h want 00000000", ram_a_o); end
      end
      checks++; if (mem_done_o !== (k == 3)) begin
        errors++; $display("FAIL wrap_done k=%0d got %b want %b", k, mem_done_o, (k == 3)); end
      if (k == 3) begin
        checks++; if (mem_rdata_o !== 32'h0000ABCD) begin
          errors++; $display("FAIL wrap_half_data got %h want 0000abcd", mem_rdata_o); end
      end
      next_cycle();
    end
    mem_req_i = 1'b0;
  endtask

  task automatic test_io_gating;
    logic [31:0] exp_if;
    exp_if = 32'h0;
    for (int k = 0; k < 4; k++) begin
      preload(32'h500 + 32'(k), 8'($urandom));
      exp_if[8*k +: 8] = ref_rd(32'h500 + 32'(k));
    end
    ref_mem[32'h00030000] = 8'h41;
    io_buffer_full_i = 1'b1;
    mem_we_i = 1'b1; mem_size_i = 2'b00; mem_addr_i = 32'h00030000; mem_wdata_i = 32'h41; mem_req_i = 1'b1;
    if_addr_i = 32'h500; if_req_i = 1'b1;
    for (int w = 0; w < 5; w++) begin
      @(negedge clk);
      checks++; if ({ram_wr_o, mem_stall_o, if_done_o} !== 3'b010) begin
        errors++; $display("FAIL io_wait w=%0d got %b want 010", w, {ram_wr_o, mem_stall_o, if_done_o}); end
      checks++; if (ram_a_o === 32'h500) begin
        errors++; $display("FAIL io_if_granted w=%0d got %h want not 00000500", w, ram_a_o); end
      next_cycle();
    end
    io_buffer_full_i = 1'b0;
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++; if ({ram_wr_o, ram_a_o, ram_dout_o} !== {1'b1, 32'h00030000, 8'h41}) begin
          errors++; $display("FAIL io_write got %b/%h/%h want 1/00030000/41", ram_wr_o, ram_a_o, ram_dout_o); end
      end
      if (k == 2) begin
        checks++; if (ram_a_o !== 32'h500) begin
          errors++; $display("FAIL io_if_accept got %h want 00000500", ram_a_o); end
      end
      if (k >= 1) begin
        checks++; if (ram_wr_o !== 1'b0) begin
          errors++; $display("FAIL io_single_write k=%0d got 1 want 0", k); end
      end
      checks++; if (mem_done_o !== (k == 1)) begin
        errors++; $display("FAIL io_done k=%0d got %b want %b", k, mem_done_o, (k == 1)); end
      checks++; if (if_done_o !== (k == 7)) begin
        errors++; $display("FAIL io_if_done k=%0d got %b want %b", k, if_done_o, (k == 7)); end
      if (k == 7) begin
        checks++; if (if_data_o !== exp_if) begin
          errors++; $display("FAIL io_if_data got %h want %h", if_data_o, exp_if); end
      end
      next_cycle();
      if (k == 1) mem_req_i = 1'b0;
    end
    if_req_i = 1'b0;
    checks++; if (ram_rd(32'h00030000) !== 8'h41) begin
      errors++; $display("FAIL io_ram got %h want 41", ram_rd(32'h00030000)); end
  endtask

  task automatic test_rdy_freeze;
    logic [31:0] exp_if;
    exp_if = 32'h0;
    for (int k = 0; k < 4; k++) begin
      preload(32'h2000 + 32'(k), 8'($urandom));
      exp_if[8*k +: 8] = ref_rd(32'h2000 + 32'(k));
    end
    if_addr_i = 32'h2000; if_req_i = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      rdy = !(k >= 2 && k <= 4);
      @(negedge clk);
      if (k >= 2 && k <= 4) begin
        checks++; if ({ram_wr_o, ram_a_o} !== {1'b0, 32'h2001}) begin
          errors++; $display("FAIL freeze_port k=%0d got %b/%h want 0/00002001", k, ram_wr_o, ram_a_o); end
      end
      checks++; if (if_done_o !== (k == 8)) begin
        errors++; $display("FAIL freeze_done k=%0d got %b want %b", k, if_done_o, (k == 8)); end
      if (k == 8) begin
        checks++; if (if_data_o !== exp_if) begin
          errors++; $display("FAIL freeze_data got %h want %h", if_data_o, exp_if); end
      end
      next_cycle();
    end
    rdy = 1'b1; if_req_i = 1'b0;
  endtask

  task automatic test_reset_midwrite;
    mem_we_i = 1'b1; mem_size_i = 2'b10; mem_addr_i = 32'h3000; mem_wdata_i = 32'h11223344; mem_req_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if ({ram_wr_o, ram_a_o} !== {1'b1, 32'h3000 + 32'(k)}) begin
        errors++; $display("FAIL mid_write k=%0d got %b/%h want 1/%h", k, ram_wr_o, ram_a_o, 32'h3000 + 32'(k)); end
      next_cycle();
    end
    ref_mem[32'h3000] = 8'h44; ref_mem[32'h3001] = 8'h33;
    rst = 1'b1; mem_req_i = 1'b0;
    @(negedge clk);
    checks++; if (ram_wr_o !== 1'b0) begin errors++; $display("FAIL mid_rst_wr got 1 want 0"); end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({if_data_o, mem_rdata_o, ram_a_o, ram_dout_o} !== 104'h0) begin
      errors++; $display("FAIL mid_rst_outputs got %h/%h/%h/%h want 0", if_data_o, mem_rdata_o, ram_a_o, ram_dout_o); end
    checks++; if ({ram_wr_o, if_done_o, mem_done_o} !== 3'b000) begin
      errors++; $display("FAIL mid_rst_strobes got %b want 000", {ram_wr_o, if_done_o, mem_done_o}); end
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if ({ram_wr_o, mem_done_o} !== 2'b00) begin
        errors++; $display("FAIL mid_after k=%0d got %b want 00", k, {ram_wr_o, mem_done_o}); end
      next_cycle();
    end
    for (int k = 0; k < 4; k++) begin
      checks++; if (ram_rd(32'h3000 + 32'(k)) !== ref_rd(32'h3000 + 32'(k))) begin
        errors++; $display("FAIL mid_ram k=%0d got %h want %h", k, ram_rd(32'h3000 + 32'(k)), ref_rd(32'h3000 + 32'(k))); end
    end
    run_xact(1'b1, 1'b0, 2'b10, 32'h3000, 32'h0, 1'b0);
  endtask

  task automatic test_random;
    logic [31:0] addr;
    bit is_mem, we;
    for (int i = 0; i < 256; i++) preload(32'h4000 + 32'(i), 8'($urandom));
    for (int i = -16; i < 16; i++) preload(32'(i), 8'($urandom));
    for (int t = 0; t < 24; t++) begin
      is_mem = ($urandom_range(0, 2) != 0);
      we     = is_mem && ($urandom_range(0, 1) == 1);
      addr   = ($urandom_range(0, 4) == 0) ? 32'hFFFFFFFD + 32'($urandom_range(0, 5))
                                           : 32'h4000 + 32'($urandom_range(0, 250));
      run_xact(is_mem, we, 2'($urandom_range(0, 3)), addr, $urandom, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1;
    if_req_i = 1'b0; if_addr_i = '0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_size_i = 2'b00; mem_addr_i = '0; mem_wdata_i = '0;
    io_buffer_full_i = 1'b0;
    test_reset();
    test_if_fetch();
    test_store_simul();
    test_wrap();
    test_io_gating();
    test_rdy_freeze();
    test_reset_midwrite();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
